// File: rtl/fetch_align_queue.sv
// Fetch-beat aligner and decode queue: extracts the instruction at each beat pc and buffers it for decode.
// Define RAFI_ALIGN_RVC_EN to enable compressed instructions and cross-line stitching of 32-bit ones.
module fetch_align_queue #(
    parameter int LINE_WIDTH  = 128,
    parameter int VADDR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   fetch_valid,
    input  logic                   fetch_fault,
    input  logic [VADDR_WIDTH-1:0] fetch_pc,
    input  logic [LINE_WIDTH-1:0]  fetch_line,
    output logic                   fetch_stall,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [VADDR_WIDTH-1:0] deq_pc,
    output logic [31:0]            deq_insn,
    output logic                   deq_compressed,
    output logic                   deq_fault
);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        RUN        = 2'd1,
        WAIT_UPPER = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t                 state_r, state_nx_s;
    logic [VADDR_WIDTH-1:0] exp_pc_r, exp_pc_nx_s;
    logic [PTR_W-1:0]       rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [VADDR_WIDTH-1:0] pc_mem_r [QUEUE_DEPTH];
    logic [31:0]            insn_mem_r [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] fault_mem_r;
    logic                   accept_s, deq_s, enq_s, enq_fault_s, do_process_s;
    logic [VADDR_WIDTH-1:0] enq_pc_s;
    logic [31:0]            enq_insn_s;
`ifdef RAFI_ALIGN_RVC_EN
    logic [QUEUE_DEPTH-1:0] comp_mem_r;
    logic [VADDR_WIDTH-1:0] pend_pc_r, pend_pc_nx_s;
    logic [15:0]            low_half_r, low_half_nx_s, hw_s, hw_up_s;
    logic [OFF_W-1:0]       hoff_s, hoff_up_s;
    logic                   hw_last_s, enq_comp_s;

    // Halfword at the beat pc and the one above it (the latter is meaningless at the line end)
    always_comb begin
        hoff_s    = fetch_pc[OFF_W-1:0] & ~OFF_W'(1);
        hoff_up_s = hoff_s + OFF_W'(2);
        hw_s      = 16'(fetch_line >> {hoff_s, 3'b000});
        hw_up_s   = 16'(fetch_line >> {hoff_up_s, 3'b000});
        hw_last_s = &fetch_pc[OFF_W-1:1];
    end
`else
    logic [OFF_W-1:0]       woff_s;
    logic [31:0]            word_s;

    // Word containing the beat pc
    always_comb begin
        woff_s = fetch_pc[OFF_W-1:0] & ~OFF_W'(3);
        word_s = 32'(fetch_line >> {woff_s, 3'b000});
    end
`endif

    // Handshake, beat classification and next-state decode
    always_comb begin
        accept_s     = fetch_valid && !fetch_stall && !flush;
        deq_s        = deq_ready && (count_r != {CNT_W{1'b0}}) && !flush;
        do_process_s = (state_r == SYNC) || ((state_r == RUN) && (fetch_pc == exp_pc_r));
        enq_s        = 1'b0;
        enq_fault_s  = 1'b0;
        enq_pc_s     = fetch_pc;
        enq_insn_s   = 32'd0;
        state_nx_s   = state_r;
        exp_pc_nx_s  = exp_pc_r;
`ifdef RAFI_ALIGN_RVC_EN
        enq_comp_s    = 1'b0;
        pend_pc_nx_s  = pend_pc_r;
        low_half_nx_s = low_half_r;
`endif
        if (accept_s && fetch_fault) begin
            enq_s       = 1'b1;
            enq_fault_s = 1'b1;
            state_nx_s  = HALTED;
`ifdef RAFI_ALIGN_RVC_EN
            if (state_r == WAIT_UPPER) begin
                enq_pc_s = pend_pc_r;
            end else begin
                enq_pc_s = fetch_pc;
            end
`endif
        end else if (accept_s && do_process_s) begin
`ifdef RAFI_ALIGN_RVC_EN
            if (hw_s[1:0] != 2'b11) begin
                enq_s       = 1'b1;
                enq_comp_s  = 1'b1;
                enq_insn_s  = {16'd0, hw_s};
                state_nx_s  = RUN;
                exp_pc_nx_s = fetch_pc + VADDR_WIDTH'(2);
            end else if (!hw_last_s) begin
                enq_s       = 1'b1;
                enq_insn_s  = {hw_up_s, hw_s};
                state_nx_s  = RUN;
                exp_pc_nx_s = fetch_pc + VADDR_WIDTH'(4);
            end else begin
                low_half_nx_s = hw_s;
                pend_pc_nx_s  = fetch_pc;
                state_nx_s    = WAIT_UPPER;
                exp_pc_nx_s   = fetch_pc + VADDR_WIDTH'(2);
            end
`else
            if (fetch_pc[1]) begin
                state_nx_s = state_r;
            end else begin
                enq_s       = 1'b1;
                enq_insn_s  = word_s;
                state_nx_s  = RUN;
                exp_pc_nx_s = fetch_pc + VADDR_WIDTH'(4);
            end
`endif
`ifdef RAFI_ALIGN_RVC_EN
        end else if (accept_s && (state_r == WAIT_UPPER) && (fetch_pc == exp_pc_r)) begin
            // Upper half of a line-crossing instruction is halfword 0 of the next line
            enq_s       = 1'b1;
            enq_pc_s    = pend_pc_r;
            enq_insn_s  = {fetch_line[15:0], low_half_r};
            state_nx_s  = RUN;
            exp_pc_nx_s = pend_pc_r + VADDR_WIDTH'(4);
`endif
        end else begin
            state_nx_s = state_r;
        end
    end

    // Alignment state registers; flush returns to Sync and drops any pending half
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            state_r  <= SYNC;
            exp_pc_r <= {VADDR_WIDTH{1'b0}};
`ifdef RAFI_ALIGN_RVC_EN
            pend_pc_r  <= {VADDR_WIDTH{1'b0}};
            low_half_r <= 16'd0;
`endif
        end else begin
            state_r  <= state_nx_s;
            exp_pc_r <= exp_pc_nx_s;
`ifdef RAFI_ALIGN_RVC_EN
            pend_pc_r  <= pend_pc_nx_s;
            low_half_r <= low_half_nx_s;
`endif
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_r[i]   <= {VADDR_WIDTH{1'b0}};
                insn_mem_r[i] <= 32'd0;
            end
            fault_mem_r <= {QUEUE_DEPTH{1'b0}};
`ifdef RAFI_ALIGN_RVC_EN
            comp_mem_r <= {QUEUE_DEPTH{1'b0}};
`endif
        end else if (enq_s) begin
            pc_mem_r[wr_ptr_r]    <= enq_pc_s;
            insn_mem_r[wr_ptr_r]  <= enq_insn_s;
            fault_mem_r[wr_ptr_r] <= enq_fault_s;
`ifdef RAFI_ALIGN_RVC_EN
            comp_mem_r[wr_ptr_r] <= enq_comp_s;
`endif
        end
    end

    // Head presentation (zeroed when empty) and backpressure, both from registers only
    always_comb begin
        deq_valid   = (count_r != {CNT_W{1'b0}});
        fetch_stall = (count_r == CNT_W'(QUEUE_DEPTH)) || (state_r == HALTED);
        if (deq_valid) begin
            deq_pc    = pc_mem_r[rd_ptr_r];
            deq_insn  = insn_mem_r[rd_ptr_r];
            deq_fault = fault_mem_r[rd_ptr_r];
`ifdef RAFI_ALIGN_RVC_EN
            deq_compressed = comp_mem_r[rd_ptr_r];
`else
            deq_compressed = 1'b0;
`endif
        end else begin
            deq_pc         = {VADDR_WIDTH{1'b0}};
            deq_insn       = 32'd0;
            deq_fault      = 1'b0;
            deq_compressed = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue; compressed-mode scenarios run when RAFI_ALIGN_RVC_EN is defined.
module tb_fetch_align_queue;
    logic         clk = 1'b0;
    logic         rst, flush, fetch_valid, fetch_fault, fetch_stall;
    logic [31:0]  fetch_pc, deq_pc, deq_insn;
    logic [127:0] fetch_line;
    logic         deq_ready, deq_valid, deq_compressed, deq_fault;
    int           n_vec = 0;
    int           n_err = 0;

    // word lines: w0 at byte 0 .. w3 at byte 12
    localparam logic [127:0] L1 = {32'h00C00693, 32'h00B00613, 32'h00A00593, 32'h00500513};
    localparam logic [127:0] L2 = {32'h00000000, 32'h00000000, 32'h00208133, 32'h00100093};
    localparam logic [127:0] L3 = {32'h00400213, 32'h00300193, 32'h00200113, 32'h00100093};
    localparam logic [127:0] L4 = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00500293};
    localparam logic [66:0]  EMPTY = 67'd0;

    always #5 clk = ~clk;

    fetch_align_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
        .fetch_pc(fetch_pc), .fetch_line(fetch_line), .fetch_stall(fetch_stall),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc),
        .deq_insn(deq_insn), .deq_compressed(deq_compressed), .deq_fault(deq_fault)
    );

    function automatic logic [66:0] head();
        return {deq_valid, deq_pc, deq_insn, deq_compressed, deq_fault};
    endfunction

    function automatic logic [66:0] ent(input logic [31:0] pc, input logic [31:0] insn,
                                        input logic c, input logic f);
        return {1'b1, pc, insn, c, f};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [127:0] line, input logic flt);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_line  = line;
        fetch_fault = flt;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_fault = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (head() !== EMPTY) begin $display("FAIL reset_head: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
        if (fetch_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", fetch_stall); n_err++; end
        n_vec++;
        rst = 1'b0;
        step();
        if (head() !== EMPTY) begin $display("FAIL reset_release: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
    endtask

    task automatic test_back_to_back();
        logic [66:0] want [3];
        want[0] = ent(32'h100, 32'h00500513, 1'b0, 1'b0);
        want[1] = ent(32'h104, 32'h00A00593, 1'b0, 1'b0);
        want[2] = ent(32'h108, 32'h00B00613, 1'b0, 1'b0);
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(32'h100 + 32'(4 * i), L1, 1'b0);
            step();
            if (head() !== want[i]) begin $display("FAIL b2b_%0d: got %h want %h", i, head(), want[i]); n_err++; end
            n_vec++;
        end
        idle();
        step();
        if (head() !== EMPTY) begin $display("FAIL b2b_drain: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
    endtask

    task automatic test_mismatch();
        do_flush();
        beat(32'h200, L2, 1'b0);
        step();
        if (head() !== ent(32'h200, 32'h00100093, 1'b0, 1'b0)) begin
            $display("FAIL mm_first: got %h want %h", head(), ent(32'h200, 32'h00100093, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        beat(32'h202, L2, 1'b0);
        step();
        if ({head(), fetch_stall} !== {EMPTY, 1'b0}) begin
            $display("FAIL mm_discard: got %h stall %b want empty stall 0", head(), fetch_stall); n_err++; end
        n_vec++;
        beat(32'h204, L2, 1'b0);
        step();
        if (head() !== ent(32'h204, 32'h00208133, 1'b0, 1'b0)) begin
            $display("FAIL mm_resume: got %h want %h", head(), ent(32'h204, 32'h00208133, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        idle();
    endtask

    task automatic test_backpressure();
        logic [66:0] want [4];
        want[0] = ent(32'h304, 32'h00200113, 1'b0, 1'b0);
        want[1] = ent(32'h308, 32'h00300193, 1'b0, 1'b0);
        want[2] = ent(32'h30C, 32'h00400213, 1'b0, 1'b0);
        want[3] = ent(32'h310, 32'h00500293, 1'b0, 1'b0);
        do_flush();
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h300 + 32'(4 * i), L3, 1'b0);
            step();
        end
        if (fetch_stall !== 1'b1) begin $display("FAIL bp_full: got stall %b want 1", fetch_stall); n_err++; end
        n_vec++;
        beat(32'h310, L4, 1'b0);
        step();
        if ({fetch_stall, head()} !== {1'b1, ent(32'h300, 32'h00100093, 1'b0, 1'b0)}) begin
            $display("FAIL bp_hold: got stall %b head %h want stall 1 head pc 300", fetch_stall, head()); n_err++; end
        n_vec++;
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        if ({fetch_stall, head()} !== {1'b0, want[0]}) begin
            $display("FAIL bp_release: got stall %b head %h want stall 0 head %h", fetch_stall, head(), want[0]); n_err++; end
        n_vec++;
        step();
        idle();
        if (fetch_stall !== 1'b1) begin $display("FAIL bp_fifth: got stall %b want 1", fetch_stall); n_err++; end
        n_vec++;
        deq_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            if (head() !== want[i]) begin $display("FAIL bp_drain_%0d: got %h want %h", i, head(), want[i]); n_err++; end
            n_vec++;
        end
        step();
    endtask

    task automatic test_fault();
        do_flush();
        deq_ready = 1'b1;
        beat(32'h500, L3, 1'b1);
        step();
        if ({fetch_stall, head()} !== {1'b1, ent(32'h500, 32'h0, 1'b0, 1'b1)}) begin
            $display("FAIL fault_entry: got stall %b head %h want stall 1 head %h", fetch_stall, head(),
                     ent(32'h500, 32'h0, 1'b0, 1'b1)); n_err++; end
        n_vec++;
        beat(32'h504, L3, 1'b0);
        step();
        step();
        if ({fetch_stall, head()} !== {1'b1, EMPTY}) begin
            $display("FAIL fault_halted: got stall %b head %h want stall 1 empty", fetch_stall, head()); n_err++; end
        n_vec++;
        idle();
        do_flush();
        if (fetch_stall !== 1'b0) begin $display("FAIL fault_flush: got stall %b want 0", fetch_stall); n_err++; end
        n_vec++;
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(32'h600 + 32'(4 * i), L3, 1'b0);
            step();
        end
        if (head() !== ent(32'h600, 32'h00100093, 1'b0, 1'b0)) begin
            $display("FAIL flush_pre: got %h want %h", head(), ent(32'h600, 32'h00100093, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        beat(32'h60C, L3, 1'b0);
        deq_ready = 1'b1;
        do_flush();
        deq_ready = 1'b0;
        if ({fetch_stall, head()} !== {1'b0, EMPTY}) begin
            $display("FAIL flush_clear: got stall %b head %h want stall 0 empty", fetch_stall, head()); n_err++; end
        n_vec++;
        beat(32'h704, L3, 1'b0);
        step();
        idle();
        if (head() !== ent(32'h704, 32'h00200113, 1'b0, 1'b0)) begin
            $display("FAIL flush_sync: got %h want %h", head(), ent(32'h704, 32'h00200113, 1'b0, 1'b0)); n_err++; end
        n_vec++;
    endtask

    task automatic test_async_reset();
        beat(32'h708, L3, 1'b0);
        step();
        idle();
        #2;
        rst = 1'b1;
        #1;
        if ({fetch_stall, head()} !== {1'b0, EMPTY}) begin
            $display("FAIL arst_now: got stall %b head %h want all 0", fetch_stall, head()); n_err++; end
        n_vec++;
        step();
        rst = 1'b0;
        step();
        if (head() !== EMPTY) begin $display("FAIL arst_after: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
    endtask

`ifdef RAFI_ALIGN_RVC_EN
    task automatic test_rvc_run();
        logic [127:0] ln;
        ln = 128'd0;
        ln[15:0] = 16'h4501;
        ln[31:16] = 16'h0513;
        do_flush();
        deq_ready = 1'b1;
        beat(32'h100, ln, 1'b0);
        step();
        if (head() !== ent(32'h100, 32'h00004501, 1'b1, 1'b0)) begin
            $display("FAIL rvc_c: got %h want %h", head(), ent(32'h100, 32'h00004501, 1'b1, 1'b0)); n_err++; end
        n_vec++;
        beat(32'h102, ln, 1'b0);
        step();
        idle();
        if (head() !== ent(32'h102, 32'h00000513, 1'b0, 1'b0)) begin
            $display("FAIL rvc_32: got %h want %h", head(), ent(32'h102, 32'h00000513, 1'b0, 1'b0)); n_err++; end
        n_vec++;
    endtask

    task automatic test_cross_line();
        logic [127:0] la, lb;
        la = 128'd0;
        la[127:112] = 16'h0093;
        lb = 128'd0;
        lb[15:0] = 16'h0010;
        lb[31:16] = 16'h4505;
        do_flush();
        deq_ready = 1'b1;
        beat(32'h10E, la, 1'b0);
        step();
        if ({fetch_stall, head()} !== {1'b0, EMPTY}) begin
            $display("FAIL xl_pending: got stall %b head %h want stall 0 empty", fetch_stall, head()); n_err++; end
        n_vec++;
        beat(32'h110, lb, 1'b0);
        step();
        if (head() !== ent(32'h10E, 32'h00100093, 1'b0, 1'b0)) begin
            $display("FAIL xl_stitch: got %h want %h", head(), ent(32'h10E, 32'h00100093, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        beat(32'h114, lb, 1'b0);
        step();
        if (head() !== EMPTY) begin $display("FAIL xl_skip: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
        beat(32'h112, lb, 1'b0);
        step();
        idle();
        if (head() !== ent(32'h112, 32'h00004505, 1'b1, 1'b0)) begin
            $display("FAIL xl_next: got %h want %h", head(), ent(32'h112, 32'h00004505, 1'b1, 1'b0)); n_err++; end
        n_vec++;
    endtask

    task automatic test_fault_wait();
        logic [127:0] ln;
        ln = 128'd0;
        ln[127:112] = 16'h0513;
        do_flush();
        deq_ready = 1'b0;
        beat(32'h3FE, ln, 1'b0);
        step();
        beat(32'h400, L3, 1'b1);
        step();
        idle();
        if ({fetch_stall, head()} !== {1'b1, ent(32'h3FE, 32'h0, 1'b0, 1'b1)}) begin
            $display("FAIL fw_entry: got stall %b head %h want stall 1 head %h", fetch_stall, head(),
                     ent(32'h3FE, 32'h0, 1'b0, 1'b1)); n_err++; end
        n_vec++;
        deq_ready = 1'b1;
        step();
        step();
        if (fetch_stall !== 1'b1) begin $display("FAIL fw_halted: got stall %b want 1", fetch_stall); n_err++; end
        n_vec++;
        do_flush();
        if (fetch_stall !== 1'b0) begin $display("FAIL fw_flush: got stall %b want 0", fetch_stall); n_err++; end
        n_vec++;
    endtask
`else
    task automatic test_word_mode();
        logic [127:0] ln;
        ln = {32'h00000000, 32'h00000000, 32'h00000513, 32'h00004501};
        do_flush();
        deq_ready = 1'b1;
        beat(32'h100, ln, 1'b0);
        step();
        if (head() !== ent(32'h100, 32'h00004501, 1'b0, 1'b0)) begin
            $display("FAIL wm_word: got %h want %h", head(), ent(32'h100, 32'h00004501, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        beat(32'h102, ln, 1'b0);
        step();
        if ({fetch_stall, head()} !== {1'b0, EMPTY}) begin
            $display("FAIL wm_half: got stall %b head %h want stall 0 empty", fetch_stall, head()); n_err++; end
        n_vec++;
        beat(32'h104, ln, 1'b0);
        step();
        if (head() !== ent(32'h104, 32'h00000513, 1'b0, 1'b0)) begin
            $display("FAIL wm_next: got %h want %h", head(), ent(32'h104, 32'h00000513, 1'b0, 1'b0)); n_err++; end
        n_vec++;
        idle();
        do_flush();
        beat(32'h10A, ln, 1'b0);
        step();
        if (head() !== EMPTY) begin $display("FAIL wm_sync_half: got %h want %h", head(), EMPTY); n_err++; end
        n_vec++;
        idle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fetch_valid = 1'b0;
        fetch_fault = 1'b0;
        fetch_pc = 32'd0;
        fetch_line = 128'd0;
        deq_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_mismatch();
        test_backpressure();
        test_fault();
        test_flush();
        test_async_reset();
`ifdef RAFI_ALIGN_RVC_EN
        test_rvc_run();
        test_cross_line();
        test_fault_wait();
`else
        test_word_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fetch_align_queue.md
# fetch_align_queue

Sits directly downstream of the instruction fetch unit and consumes its per-cycle beat (valid, fault, pc, I-cache line). It extracts the 16- or 32-bit instruction at the beat's pc, stitches 32-bit instructions that cross a cache line, and discards beats that do not start at the expected next pc. Aligned instructions go into a small FIFO feeding decode. FIFO-full backpressure is driven into the fetch unit's stall input.

## Interface
- LINE_WIDTH, 128: I-cache line width in bits; power of two, at least 32.
- VADDR_WIDTH, 32: virtual pc width.
- QUEUE_DEPTH, 4: FIFO entries; power of two, at least 2.

- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- flush  in  1  pipeline redirect; discards all held state.
- fetch_valid  in  1  fetch beat valid.
- fetch_fault  in  1  beat carries an instruction page fault.
- fetch_pc  in  VADDR_WIDTH  beat pc.
- fetch_line  in  LINE_WIDTH  I-cache line containing fetch_pc.
- fetch_stall  out  1  backpressure to fetch.
- deq_ready  in  1  decode accepts the head entry.
- deq_valid  out  1  head entry valid.
- deq_pc  out  VADDR_WIDTH  instruction pc.
- deq_insn  out  32  instruction; a compressed instruction is zero-extended.
- deq_compressed  out  1  instruction is 16-bit.
- deq_fault  out  1  entry is a fetch fault; deq_insn is 0.

## Operation
- Handshake and backpressure:
  - Accept = fetch_valid && !fetch_stall && !flush.
  - fetch_stall = queue full || state==Halted. It is a function of registers only.
  - A beat that is not accepted is assumed to be re-presented by fetch. It is never partially consumed.
- Halfword selection:
  - hidx = fetch_pc[$clog2(LINE_WIDTH/8)-1:1]; hw = fetch_line[16*hidx +: 16].
  - hw[1:0] != 2'b11 means compressed. Otherwise the instruction is 32-bit.
- State machine, encoded in a 2-bit register:
  - Sync: accept any pc.
    - Compressed: enqueue, then go to Run with exp_pc = pc+2.
    - 32-bit with hidx < last: the upper half is hw at hidx+1. Enqueue, then go to Run with exp_pc = pc+4.
    - 32-bit with hidx == last: latch the low half and pend_pc = pc. Go to WaitUpper with exp_pc = pc+2. Nothing is enqueued.
  - Run: a beat with pc != exp_pc is consumed and discarded, with no state change. A beat whose pc matches is processed as in Sync.
  - WaitUpper:
    - A matching beat supplies halfword 0 as the upper half. Enqueue {hw0, low} with pc = pend_pc, then go to Run with exp_pc = pend_pc+4.
    - A non-matching beat is discarded.
  - Halted: entered on any accepted fault beat. Exits only on flush.
- Fault beat (any state, pc match not required):
  - Enqueue a fault entry: pc = pend_pc in WaitUpper, else fetch_pc.
  - The entry has insn = 0 and compressed = 0. Then go to Halted.
- Flush:
  - Highest priority. Clears the queue and the pending half, and goes to Sync.
  - The beat and the dequeue in the flush cycle are ignored.
- Pc arithmetic is modulo 2^VADDR_WIDTH.
- The FIFO uses rd/wr pointers of $clog2(QUEUE_DEPTH) bits plus a count of $clog2(QUEUE_DEPTH)+1 bits. Pointers wrap naturally.

## Timing
- Reset values:
  - state = Sync; queue empty.
  - deq_valid = 0, deq_pc = 0, deq_insn = 0, deq_compressed = 0, deq_fault = 0.
  - fetch_stall = 0; exp_pc = 0; pend_pc = 0.
- Latency: an accepted beat appears at the FIFO head 1 cycle later if the queue was empty. There is no combinational bypass.
- Outputs are registered FIFO-head values. deq_* are 0 when deq_valid = 0.
- Simultaneous enqueue and dequeue while not full: the count is unchanged.
- When full, no enqueue occurs even if deq_ready = 1 in the same cycle. fetch_stall deasserts the cycle after the dequeue.
- Flush sets deq_valid = 0 and fetch_stall = 0 in the next cycle.
- Asynchronous reset mid-operation drops all entries and any pending half immediately.

## Configuration
- RAFI_ALIGN_RVC_EN defined:
  - Compressed instructions are supported as above.
  - The WaitUpper state and the pending-half register exist.
- Undefined:
  - Every instruction is 32 bits, taken from word fetch_pc[..:2].
  - Beats with fetch_pc[1] = 1 are discarded.
  - deq_compressed is tied to 0, WaitUpper and the pending register are removed, and exp_pc always advances by 4.

## Test plan
- Run from reset:
  - pc 0x100 with a line whose hw0 = 0x4501 (compressed) and hw1/hw2 = 0x0513/0x0000.
  - Then a beat at pc 0x102.
  - Expect entry {0x100, 0x00004501, c=1}, then {0x102, 0x00000513, c=0}.
- Cross-line instruction:
  - pc 0x10E with hw7 = 0x0093, then a beat at pc 0x110 with hw0 = 0x0010.
  - Expect one entry {0x10E, 0x00100093}, and exp_pc = 0x112.
- Mismatch discard: in Run with exp_pc = 0x204, a beat at pc 0x202 → no entry, beat consumed, fetch_stall = 0.
- Backpressure:
  - With deq_ready = 0, send 4 valid beats. Expect fetch_stall = 1 and a 5th beat not consumed.
  - Raise deq_ready for 1 cycle. Expect fetch_stall = 0 on the next cycle and the 5th beat accepted.
- Fault in WaitUpper:
  - pending at pc 0x3FE, then a fault beat at 0x400.
  - Expect a fault entry with pc 0x3FE and insn 0, then fetch_stall = 1 until flush.
- Flush plus reset:
  - Flush with 3 entries queued → deq_valid = 0 next cycle, state Sync.
  - Assert rst asynchronously mid-cycle → all outputs 0 immediately.
